comparador_param: RTL and testbench
===================================

Name: comparador_param

Overview:
- Parametrised, registered successor to the 2-bit equality comparator.
- Compares a stream of word pairs `a`/`b` of WIDTH bits under a valid/ready handshake.
- Each accepted pair yields registered equal/greater/less flags, in unsigned or two's-complement mode.
- A frame FSM groups words into frames and reports whole-frame equality plus a saturating mismatch count; it sits between data sources and the checker logic on the FPGA.

Parameters:
- WIDTH, 8, bit width of a and b (>=1)
- CNT_W, 16, width of the per-frame mismatch counter (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pair present
- in_ready  out  1  block can accept a pair this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the pair
- frame_start  in  1  accepted pair is the first of a frame
- frame_last  in  1  accepted pair is the last of a frame
- out_valid  out  1  result registers hold a result
- out_ready  in  1  downstream accepts the result
- aeqb  out  1  a == b
- agtb  out  1  a > b
- altb  out  1  a < b
- frame_done  out  1  this result closes a frame
- frame_eq  out  1  all pairs of the closed frame were equal; meaningful only with frame_done
- mism_count  out  CNT_W  mismatches in the current/just-closed frame, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, aeqb=0, agtb=0, altb=0, frame_done=0, frame_eq=0, mism_count=0, FSM=IDLE. Effective immediately, including mid-frame; a partial frame is discarded with no frame_done.
- Handshake and output register:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer).
  - Latency: result visible on outputs 1 cycle after acceptance.
  - out_valid clears when out_ready=1 and no new pair is accepted.
  - While out_valid && !out_ready, all outputs hold stable.
- Compare rules:
  - Exactly one of aeqb/agtb/altb is 1 whenever out_valid=1.
  - signed_mode=1: MSB is the sign bit (WIDTH=1: value 1 reads as -1).
  - Flags keep their last values while out_valid=0.
- Frame FSM, states IDLE and ACTIVE; all transitions occur on accepted pairs only:
  - Pair with frame_start=1: counter is first cleared; counter takes 1 if a!=b else 0; error flag takes a!=b.
  - frame_start=1 in ACTIVE: previous frame abandoned, no frame_done for it, new frame begins.
  - frame_start=0 in ACTIVE: counter += (a!=b), saturating at 2^CNT_W-1; error flag |= (a!=b).
  - frame_last=1 with a frame open (ACTIVE, or frame_start=1 on the same pair): result carries frame_done=1 and frame_eq=!error (including this pair); FSM -> IDLE. start+last on one pair is a one-word frame.
  - frame_start=0 in IDLE: pair compared normally, counter and FSM untouched; frame_last ignored, frame_done=0.
  - Otherwise the FSM stays in ACTIVE; frame_done=0.
- mism_count is registered with the result:
  - Shows the count including the current pair.
  - Holds after frame close until the next frame_start.
  - Not altered by out-of-frame pairs.
- frame_done and frame_eq are per-result: asserted only with the result of the closing pair, cleared with the next accepted result.

Optional Feature:
COMPARADOR_MASK_EN
- Defined: adds input `mask [WIDTH]`, sampled with the pair.
  - Bits with mask=1 are ignored.
  - Equality and magnitude use (a & ~mask) vs (b & ~mask).
  - In signed mode a masked sign bit reads as 0.
  - mask all ones forces aeqb=1.
- Undefined: no mask port; full-width compare.

Test Plan:
- Reset then single pairs, WIDTH=8, out_ready=1: (a=0,b=0)->aeqb=1; (1,0)->agtb=1; (1,1)->aeqb=1; (2,3)->altb=1; each 1 cycle after accept.
- Signed mode: a=8'hFF, b=8'h01. signed_mode=1 -> altb=1; signed_mode=0 -> agtb=1.
- Frame of 4 pairs with mismatches at words 2 and 4 -> last result: frame_done=1, frame_eq=0, mism_count=2. Then a one-word equal frame (start+last) -> frame_done=1, frame_eq=1, mism_count=0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after first accept, outputs stable, no pair lost. Release -> results drain in order.
- CNT_W=2, frame of 6 mismatching pairs -> mism_count saturates at 3. Also: rst_n pulsed low mid-frame -> outputs 0 asynchronously, no frame_done.
- With COMPARADOR_MASK_EN: a=8'hA5, b=8'hA4, mask=8'h01 -> aeqb=1. Same pair with mask=0 -> agtb=1.

Source files
------------

// File: rtl/comparador_param.sv
// comparador_param: registered WIDTH-bit a/b comparator with valid/ready handshake and frame checking.
// Define COMPARADOR_MASK_EN to add a per-bit ignore mask input.
module comparador_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             frame_start,
    input  logic             frame_last,
`ifdef COMPARADOR_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb,
    output logic             frame_done,
    output logic             frame_eq,
    output logic [CNT_W-1:0] mism_count
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic out_valid_q, aeqb_q, agtb_q, altb_q, done_q, feq_q, err_q;
    logic out_valid_d, err_d, done_d, feq_d, open_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ma, mb;
    logic signed [WIDTH:0] sa, sb;
    logic accept, ne;
`ifdef COMPARADOR_MASK_EN
    assign ma = a & ~mask;
    assign mb = b & ~mask;
`else
    assign ma = a;
    assign mb = b;
`endif
    // One extra bit carries the sign in signed mode and zero otherwise, so a single signed compare serves both modes.
    assign sa = {signed_mode & ma[WIDTH-1], ma};
    assign sb = {signed_mode & mb[WIDTH-1], mb};
    assign ne = ma != mb;
    assign in_ready = !out_valid_q || out_ready;
    assign accept = in_valid && in_ready;
    assign out_valid_d = accept || (out_valid_q && !out_ready);
    always_comb begin
        open_d  = frame_start || state_q == ACTIVE;
        cnt_d   = frame_start ? CNT_W'(ne)
                : (state_q == ACTIVE && ne && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        err_d   = frame_start ? ne : err_q | (state_q == ACTIVE && ne);
        done_d  = open_d && frame_last;
        feq_d   = done_d && !err_d;
        state_d = (open_d && !frame_last) ? ACTIVE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            aeqb_q      <= 1'b0;
            agtb_q      <= 1'b0;
            altb_q      <= 1'b0;
            done_q      <= 1'b0;
            feq_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                aeqb_q  <= !ne;
                agtb_q  <= sa > sb;
                altb_q  <= sa < sb;
                done_q  <= done_d;
                feq_q   <= feq_d;
                err_q   <= err_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end
    end
    assign out_valid  = out_valid_q;
    assign aeqb       = aeqb_q;
    assign agtb       = agtb_q;
    assign altb       = altb_q;
    assign frame_done = done_q;
    assign frame_eq   = feq_q;
    assign mism_count = cnt_q;
endmodule

// File: tb/tb_comparador_param.sv
// tb_comparador_param: directed and random checks of comparador_param against a queue-based reference model.
module tb_comparador_param;
    localparam int W = 8;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, mask = '0;
    logic signed_mode = 1'b0, frame_start = 1'b0, frame_last = 1'b0;
    logic aeqb, agtb, altb, frame_done, frame_eq;
    logic [CW-1:0] mism_count;
    int checks = 0, errors = 0;
    typedef struct {bit eq, gt, lt, done, feq; int cnt;} res_t;
    res_t exp_q[$];
    bit m_open = 0, m_err = 0;
    int m_cnt = 0;

    comparador_param #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .frame_start(frame_start), .frame_last(frame_last),
`ifdef COMPARADOR_MASK_EN
        .mask(mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .aeqb(aeqb), .agtb(agtb), .altb(altb),
        .frame_done(frame_done), .frame_eq(frame_eq), .mism_count(mism_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Interpret operands as integers according to the mode, then apply frame rules.
    task automatic model(input logic [W-1:0] ta, tb, input bit sm, fs, fl);
        res_t r;
        logic [W-1:0] xa, xb;
        int va, vb;
        bit nq, open;
`ifdef COMPARADOR_MASK_EN
        xa = ta & ~mask; xb = tb & ~mask;
`else
        xa = ta; xb = tb;
`endif
        va = int'(xa); vb = int'(xb);
        if (sm && xa[W-1]) va -= (1 << W);
        if (sm && xb[W-1]) vb -= (1 << W);
        nq = (va != vb);
        r.eq = (va == vb); r.gt = (va > vb); r.lt = (va < vb);
        open = 1;
        if (fs) begin
            m_cnt = nq ? 1 : 0;
            m_err = nq;
        end else if (m_open) begin
            if (nq && m_cnt < MAXC) m_cnt++;
            m_err |= nq;
        end else open = 0;
        r.done = open && fl;
        r.feq = r.done && !m_err;
        r.cnt = m_cnt;
        m_open = open && !fl;
        exp_q.push_back(r);
    endtask

    task automatic send(input logic [W-1:0] ta, tb, input bit sm, fs, fl);
        int n = 0;
        a = ta; b = tb; signed_mode = sm; frame_start = fs; frame_last = fl; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", n < 50, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(ta, tb, sm, fs, fl);
    endtask

    task automatic cmp_front(input string tag);
        res_t r = exp_q[0];
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".aeqb"}, aeqb, r.eq);
        chk({tag, ".agtb"}, agtb, r.gt);
        chk({tag, ".altb"}, altb, r.lt);
        chk({tag, ".frame_done"}, frame_done, r.done);
        chk({tag, ".frame_eq"}, frame_eq, r.feq);
        chk({tag, ".mism_count"}, mism_count, r.cnt);
    endtask

    task automatic check_out(input string tag);
        if (exp_q.size() == 0) chk({tag, ".no_expectation"}, 0, 1);
        else begin
            cmp_front(tag);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.flags", {aeqb, agtb, altb, frame_done, frame_eq}, 0);
        chk("rst.mism_count", mism_count, 0);
        rst_n = 1'b1;
        send(8'd0, 8'd0, 0, 0, 0); check_out("p00");
        send(8'd1, 8'd0, 0, 0, 0); check_out("p10");
        chk("p10.agtb_const", agtb, 1);
        send(8'd1, 8'd1, 0, 0, 0); check_out("p11");
        send(8'd2, 8'd3, 0, 0, 0); check_out("p23");
        chk("p23.altb_const", altb, 1);
        send(8'hFF, 8'h01, 1, 0, 0); check_out("signed");
        chk("signed.altb_const", altb, 1);
        send(8'hFF, 8'h01, 0, 0, 0); check_out("unsigned");
        chk("unsigned.agtb_const", agtb, 1);
        send(8'd5, 8'd5, 0, 1, 0); check_out("f4w1");
        send(8'd3, 8'd4, 0, 0, 0); check_out("f4w2");
        send(8'd7, 8'd7, 0, 0, 0); check_out("f4w3");
        send(8'd9, 8'd1, 0, 0, 1); check_out("f4w4");
        chk("f4.done_const", {frame_done, frame_eq, 2'(mism_count)}, 4'b1010);
        send(8'd6, 8'd6, 0, 1, 1); check_out("f1");
        chk("f1.done_const", {frame_done, frame_eq, 2'(mism_count)}, 4'b1100);
        // backpressure: drain, then stall with a second pair waiting
        @(posedge clk); #1;
        chk("drain.out_valid", out_valid, 0);
        out_ready = 1'b0;
        send(8'd10, 8'd20, 0, 0, 0);
        a = 8'd30; b = 8'd20; signed_mode = 0; frame_start = 0; frame_last = 0; in_valid = 1'b1;
        repeat (5) begin
            chk("bp.in_ready", in_ready, 0);
            cmp_front("bp.hold");
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        model(8'd30, 8'd20, 0, 0, 0);
        check_out("bp.second");
        // saturation at 3 with CNT_W=2
        send(8'd1, 8'd2, 0, 1, 0); check_out("sat1");
        for (int i = 0; i < 4; i++) begin
            send(8'd1, 8'd2, 0, 0, 0); check_out("satn");
        end
        send(8'd1, 8'd2, 0, 0, 1); check_out("sat6");
        chk("sat.count_const", mism_count, 3);
`ifdef COMPARADOR_MASK_EN
        mask = 8'h01;
        send(8'hA5, 8'hA4, 0, 0, 0); check_out("mask1");
        chk("mask1.aeqb_const", aeqb, 1);
        mask = 8'h00;
        send(8'hA5, 8'hA4, 0, 0, 0); check_out("mask0");
        chk("mask0.agtb_const", agtb, 1);
`endif
        for (int i = 0; i < 300; i++) begin
`ifdef COMPARADOR_MASK_EN
            mask = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
            send(W'($urandom), ($urandom_range(0, 2) == 0) ? a : W'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            check_out("rand");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("rand.idle_valid", out_valid, 0);
            end
        end
        // asynchronous reset mid-frame
        send(8'd1, 8'd2, 0, 1, 0); check_out("rf1");
        send(8'd3, 8'd4, 0, 0, 0); check_out("rf2");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.flags", {aeqb, agtb, altb, frame_done, frame_eq}, 0);
        chk("arst.mism_count", mism_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_open = 0; m_err = 0; m_cnt = 0;
        send(8'd5, 8'd5, 0, 0, 1); check_out("post_rst");
        chk("post_rst.done_const", frame_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
